rice_stream_writer: RTL and testbench
=====================================

RICE_STREAM_WRITER -- requirements
Module: rice_stream_writer

Interface
REQ-001 The block SHALL have parameter RES_WIDTH, default 16: residual width in bits.
REQ-002 The block SHALL have parameter PARAM_WIDTH, default 4: Rice parameter width in bits.
REQ-003 The block SHALL have port iClock, input, 1: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port iReset, input, 1: reset, synchronous and active-low.
REQ-005 The block SHALL have port iValid, input, 1: iResidual and iRiceParam are valid.
REQ-006 The block SHALL have port oReady, output, 1: the block accepts a residual this cycle.
REQ-007 The block SHALL have port iResidual, input, RES_WIDTH: signed two's-complement residual.
REQ-008 The block SHALL have port iRiceParam, input, PARAM_WIDTH: Rice parameter k, range 0..15.
REQ-009 The block SHALL have port oData, output, 1: current serial code bit.
REQ-010 The block SHALL have port oValid, output, 1: oData holds a valid bit.
REQ-011 The block SHALL have port iReady, input, 1: downstream consumes oData when oValid and iReady are both high.
REQ-012 The block SHALL have port oLast, output, 1: oData is the final bit of the current codeword.

Function
REQ-013 A residual SHALL be accepted on any rising edge with iValid and oReady high; iResidual and iRiceParam SHALL be latched at that edge.
REQ-014 Zigzag mapping: u = 2x for x >= 0, u = -2x-1 for x < 0.
REQ-015 u SHALL be RES_WIDTH bits unsigned, with no overflow; x = -32768 maps to u = 65535.
REQ-016 Split: q = u >> k; r = u mod 2^k.
REQ-017 Bit order per codeword: q ones, then a single 0 stop bit, then the k bits of r MSB-first; total q+1+k bits.
REQ-018 The state machine SHALL have states IDLE, UNARY, STOP and REM.
REQ-019 On accept, the next state SHALL be UNARY if q > 0, else STOP.
REQ-020 UNARY SHALL drive oData=1 and decrement the q counter per transferred bit; on the last transfer it SHALL go to STOP.
REQ-021 STOP SHALL drive oData=0 and, after the transfer, go to REM if k > 0, else end the codeword.
REQ-022 REM SHALL drive r[bit index] starting at k-1 and decrement the index per transfer; it SHALL end the codeword after index 0.
REQ-023 Latency: first bit SHALL appear with oValid high on the cycle after the accept edge.
REQ-024 oValid SHALL be high in UNARY, STOP and REM, and low in IDLE.
REQ-025 While iReady is low, oData, oLast, the state and all counters SHALL hold.
REQ-026 oLast SHALL be high on the stop bit when k=0, else on r bit 0.
REQ-027 oReady SHALL be high in IDLE, and high when oValid, oLast and iReady are all high (back-to-back accept).
REQ-028 oReady SHALL be low otherwise.
REQ-029 On a back-to-back accept, the new codeword's first bit SHALL follow the previous last bit with no bubble.
REQ-030 If the last bit transfers with no new accept, the state SHALL return to IDLE.
REQ-031 The q counter SHALL be RES_WIDTH bits; q up to 65535 (k=0) SHALL be supported, with no escape code.
REQ-032 iValid while oReady is low SHALL be ignored; the upstream holds its data.

Reset
REQ-033 While iReset is low at a rising edge, the state SHALL go to IDLE and counters and latched values SHALL clear.
REQ-034 Outputs under reset SHALL be oValid=0, oData=0, oLast=0, oReady=0.
REQ-035 oReady SHALL rise on the first edge after iReset goes high.
REQ-036 Reset mid-codeword SHALL abandon the codeword with no further bits emitted.

Structure
REQ-037 The state encoding, RES_WIDTH/PARAM_WIDTH defaults and the zigzag width rule SHALL reside in the shared FLAC package/header used by the Rice reader and writer.
REQ-038 Zigzag mapping SHALL be one combinational sub-module, rice_zigzag_map (signed x in, unsigned u out).
REQ-039 rice_zigzag_map SHALL be reusable in inverse form by the reader side.
REQ-040 All sequencing SHALL live in rice_stream_writer.

Verification
REQ-041 Scenario: x=-23, k=3, iReady=1 -> u=45, bits 1,1,1,1,1,0,1,0,1 on consecutive cycles; oLast on the 9th bit.
REQ-042 Scenario: x=11, x=1 back-to-back, k=3 -> 1,1,0,1,1,0 then 0,0,1,0 with no gap; oReady high on each oLast cycle.
REQ-043 Scenario: x=0, k=0 -> single bit 0 with oLast; then IDLE with oReady=1.
REQ-044 Scenario: x=-32768, k=15 -> u=65535, bits 1,0, then fifteen 1s; 17 bits total.
REQ-045 Scenario: x=-23, k=3, iReady toggled 1/0 every cycle -> same 9-bit sequence; oData stable during stall cycles; a reference decode in the bench recovers -23.
REQ-046 Scenario: iReset low after the 4th bit of x=-23 -> oValid=0 next cycle; no remaining bits emitted; the next residual encodes correctly.

Source files
------------

// File: rtl/rice_stream_writer_pkg.sv
// Shared FLAC Rice definitions: default widths, writer/reader FSM encoding and
// the zigzag width rule (u is as wide as the residual; the full range folds losslessly).
package rice_stream_writer_pkg;

  localparam int RICE_RES_WIDTH   = 16;
  localparam int RICE_PARAM_WIDTH = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_UNARY = 2'd1;
  localparam logic [1:0] ST_STOP  = 2'd2;
  localparam logic [1:0] ST_REM   = 2'd3;

  function automatic int zz_width(input int res_width);
    return res_width;
  endfunction

endpackage

// File: rtl/rice_zigzag_map.sv
// Combinational zigzag fold (signed x -> unsigned u); INVERSE=1 unfolds u -> x.
// Zero latency, no flow control.
module rice_zigzag_map #(
  parameter int W       = 16,
  parameter bit INVERSE = 1'b0
) (
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  always_comb begin
    if (!INVERSE) begin
      data_o = {data_i[W-2:0], 1'b0} ^ {W{data_i[W-1]}};
    end else begin
      data_o = {1'b0, data_i[W-1:1]} ^ {W{data_i[0]}};
    end
  end

endmodule

// File: rtl/rice_stream_writer.sv
// Serialises one Rice codeword per accepted residual, one bit per transfer; first bit
// the cycle after accept; iReady low freezes everything; back-to-back accept on the last bit.
module rice_stream_writer
  import rice_stream_writer_pkg::*;
#(
  parameter int RES_WIDTH   = RICE_RES_WIDTH,
  parameter int PARAM_WIDTH = RICE_PARAM_WIDTH
) (
  input  logic                   iClock,
  input  logic                   iReset,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [RES_WIDTH-1:0]   iResidual,
  input  logic [PARAM_WIDTH-1:0] iRiceParam,
  output logic                   oData,
  output logic                   oValid,
  input  logic                   iReady,
  output logic                   oLast
);

  localparam int UW = zz_width(RES_WIDTH);
  localparam logic [RES_WIDTH-1:0]   Q_ONE = RES_WIDTH'(1);
  localparam logic [PARAM_WIDTH-1:0] K_ONE = PARAM_WIDTH'(1);

  logic [1:0]             state_q, state_d;
  logic [RES_WIDTH-1:0]   q_cnt_q, q_cnt_d;
  logic [RES_WIDTH-1:0]   r_q, r_d;
  logic [PARAM_WIDTH-1:0] k_q, k_d;
  logic [PARAM_WIDTH-1:0] idx_q, idx_d;
  logic                   rdy_en_q;

  logic [UW-1:0]        zz_u;
  logic [RES_WIDTH-1:0] new_q, new_r;
  logic                 xfer, accept;

  rice_zigzag_map #(.W(UW), .INVERSE(1'b0)) u_zigzag (
    .data_i (iResidual),
    .data_o (zz_u)
  );

  assign new_q = zz_u >> iRiceParam;
  assign new_r = zz_u & ~({UW{1'b1}} << iRiceParam);

  always_comb begin
    oValid = (state_q != ST_IDLE);
    oData  = 1'b0;
    case (state_q)
      ST_UNARY: oData = 1'b1;
      ST_REM:   oData = r_q[idx_q];
      default:  oData = 1'b0;
    endcase
    oLast  = ((state_q == ST_STOP) && (k_q == '0)) || ((state_q == ST_REM) && (idx_q == '0));
    xfer   = oValid && iReady;
    // rdy_en_q keeps oReady low until the first edge after reset is released
    oReady = rdy_en_q && ((state_q == ST_IDLE) || (xfer && oLast));
    accept = iValid && oReady;
  end

  always_comb begin
    state_d = state_q;
    q_cnt_d = q_cnt_q;
    r_d     = r_q;
    k_d     = k_q;
    idx_d   = idx_q;
    if (xfer) begin
      case (state_q)
        ST_UNARY: begin
          q_cnt_d = q_cnt_q - Q_ONE;
          if (q_cnt_q == Q_ONE) state_d = ST_STOP;
        end
        ST_STOP: begin
          if (k_q != '0) begin
            state_d = ST_REM;
            idx_d   = k_q - K_ONE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_REM: begin
          if (idx_q == '0) state_d = ST_IDLE;
          else             idx_d   = idx_q - K_ONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (accept) begin
      state_d = (new_q != '0) ? ST_UNARY : ST_STOP;
      q_cnt_d = new_q;
      r_d     = new_r;
      k_d     = iRiceParam;
    end
  end

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state_q  <= ST_IDLE;
      q_cnt_q  <= '0;
      r_q      <= '0;
      k_q      <= '0;
      idx_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_cnt_q  <= q_cnt_d;
      r_q      <= r_d;
      k_q      <= k_d;
      idx_q    <= idx_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rice_stream_writer.sv
// Self-checking bench: vector table, hand sequences and randomized traffic against a bit-queue model.
module tb_rice_stream_writer;

  logic        iClock = 1'b0;
  logic        iReset = 1'b0;
  logic        iValid = 1'b0;
  logic        iReady = 1'b0;
  logic [15:0] iResidual = '0;
  logic [3:0]  iRiceParam = '0;
  logic        oReady, oData, oValid, oLast;

  always #5 iClock = ~iClock;

  rice_stream_writer #(.RES_WIDTH(16), .PARAM_WIDTH(4)) dut (
    .iClock     (iClock),
    .iReset     (iReset),
    .iValid     (iValid),
    .oReady     (oReady),
    .iResidual  (iResidual),
    .iRiceParam (iRiceParam),
    .oData      (oData),
    .oValid     (oValid),
    .iReady     (iReady),
    .oLast      (oLast)
  );

  typedef struct { logic d; logic l; } exp_t;
  typedef struct { logic [15:0] x; logic [3:0] k; int nbits; logic [31:0] pat; } vec_t;

  exp_t        exp_q[$];
  bit          got_q[$];
  logic [15:0] pend_x[$];
  logic [3:0]  pend_k[$];
  int          checks = 0;
  int          errors = 0;
  logic        prev_stall = 1'b0, prev_d = 1'b0, prev_l = 1'b0, prev_rst = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, $signed(got), $signed(want));
    end
  endtask

  // Expected bits from the Rice definition using plain integer arithmetic.
  function automatic void push_model(input logic [15:0] x, input logic [3:0] k);
    int xi = int'($signed(x));
    int ki = int'(k);
    int u  = (xi >= 0) ? 2 * xi : -2 * xi - 1;
    int q  = u / (1 << ki);
    int r  = u % (1 << ki);
    for (int i = 0; i < q; i++) exp_q.push_back('{1'b1, 1'b0});
    exp_q.push_back('{1'b0, ki == 0});
    for (int i = ki - 1; i >= 0; i--) exp_q.push_back('{((r >> i) & 1) != 0, i == 0});
  endfunction

  function automatic int decode(input int k);
    int i = 0, q = 0, r = 0, u;
    while (i < got_q.size() && got_q[i]) begin q++; i++; end
    i++;
    for (int j = 0; j < k; j++) begin
      r = r * 2 + ((i < got_q.size()) ? int'(got_q[i]) : 0);
      i++;
    end
    u = q * (1 << k) + r;
    return (u % 2 != 0) ? -(u + 1) / 2 : u / 2;
  endfunction

  function automatic logic [31:0] got_pattern();
    logic [31:0] p = '0;
    foreach (got_q[i]) p = (p << 1) | 32'(got_q[i]);
    return p;
  endfunction

  task automatic cycle(input logic v, input logic [15:0] x, input logic [3:0] k,
                       input logic rdy, input logic rst_n, output logic acc);
    exp_t e;
    @(negedge iClock);
    iValid = v; iResidual = x; iRiceParam = k; iReady = rdy; iReset = rst_n;
    #1;
    acc = 1'b0;
    if (!rst_n) begin
      if (!prev_rst) begin
        chk("rst_valid", oValid, 0);
        chk("rst_data", oData, 0);
        chk("rst_last", oLast, 0);
        chk("rst_ready", oReady, 0);
      end
      exp_q.delete();
      prev_stall = 1'b0;
      prev_rst   = 1'b0;
      return;
    end
    if (!prev_rst) begin
      chk("rel_ready_low", oReady, 0);
      chk("rel_valid_low", oValid, 0);
    end else if (!oValid) begin
      chk("idle_ready", oReady, 1);
      chk("no_bubble", exp_q.size(), 0);
    end
    if (prev_stall) begin
      chk("stall_valid", oValid, 1);
      chk("stall_data", oData, prev_d);
      chk("stall_last", oLast, prev_l);
    end
    if (oValid) chk("busy_ready", oReady, oLast && rdy);
    if (oValid && rdy) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_bit got %0d want none", oData);
      end else begin
        e = exp_q.pop_front();
        chk("bit_data", oData, e.d);
        chk("bit_last", oLast, e.l);
      end
      got_q.push_back(oData);
    end
    acc = v && oReady;
    if (acc) push_model(x, k);
    prev_stall = oValid && !rdy;
    prev_d     = oData;
    prev_l     = oLast;
    prev_rst   = 1'b1;
  endtask

  // rmode: 0 iReady=1, 1 toggle, 2 random; vmode: 0 iValid whenever data pending, 1 random gaps.
  task automatic run_queue(input int rmode, input int vmode, input int budget, output int ncyc);
    logic acc, v, rdy, done;
    done = 1'b0;
    ncyc = budget;
    for (int c = 0; c < budget && !done; c++) begin
      v   = (pend_x.size() > 0) && (vmode == 0 || $urandom_range(0, 9) < 7);
      rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? (c % 2 == 0) : ($urandom_range(0, 9) < 7);
      if (v) cycle(1'b1, pend_x[0], pend_k[0], rdy, 1'b1, acc);
      else   cycle(1'b0, 16'($urandom), 4'($urandom), rdy, 1'b1, acc);
      if (acc) begin void'(pend_x.pop_front()); void'(pend_k.pop_front()); end
      if (pend_x.size() == 0 && exp_q.size() == 0) begin done = 1'b1; ncyc = c + 1; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout got %0d pending bits want 0", exp_q.size());
    end
  endtask

  initial begin
    vec_t vecs[8];
    logic acc;
    int   ncyc;

    vecs[0] = '{-16'sd23,   4'd3,  9, 32'b111110101};
    vecs[1] = '{16'sd11,    4'd3,  6, 32'b110110};
    vecs[2] = '{16'sd1,     4'd3,  4, 32'b0010};
    vecs[3] = '{16'sd0,     4'd0,  1, 32'b0};
    vecs[4] = '{16'h8000,   4'd15, 17, 32'b10111111111111111};
    vecs[5] = '{16'sd32767, 4'd15, 17, 32'b10111111111111110};
    vecs[6] = '{16'sd5,     4'd0,  11, 32'b11111111110};
    vecs[7] = '{-16'sd1,    4'd2,  3, 32'b001};

    repeat (3) cycle(1'b1, 16'd7, 4'd1, 1'b1, 1'b0, acc);
    cycle(1'b0, 16'd0, 4'd0, 1'b1, 1'b1, acc);
    cycle(1'b0, 16'd0, 4'd0, 1'b1, 1'b1, acc);

    foreach (vecs[i]) begin
      got_q.delete();
      pend_x.push_back(vecs[i].x); pend_k.push_back(vecs[i].k);
      run_queue(0, 0, 100, ncyc);
      chk("vec_nbits", got_q.size(), vecs[i].nbits);
      chk("vec_latency", ncyc, vecs[i].nbits + 1);
      chk("vec_pattern", got_pattern(), vecs[i].pat);
      chk("vec_decode", decode(int'(vecs[i].k)), 32'($signed(vecs[i].x)));
      cycle(1'b0, 16'd0, 4'd0, 1'b1, 1'b1, acc);
    end

    got_q.delete();
    pend_x.push_back(16'd11); pend_k.push_back(4'd3);
    pend_x.push_back(16'd1);  pend_k.push_back(4'd3);
    run_queue(0, 0, 100, ncyc);
    chk("b2b_pattern", got_pattern(), 32'b1101100010);
    chk("b2b_cycles", ncyc, 11);

    got_q.delete();
    pend_x.push_back(-16'sd23); pend_k.push_back(4'd3);
    run_queue(1, 0, 100, ncyc);
    chk("stall_pattern", got_pattern(), 32'b111110101);
    chk("stall_decode", decode(3), -32'sd23);

    got_q.delete();
    cycle(1'b1, -16'sd23, 4'd3, 1'b1, 1'b1, acc);
    chk("mid_rst_accept", acc, 1);
    for (int c = 0; c < 20 && got_q.size() < 4; c++) cycle(1'b0, 16'd0, 4'd0, 1'b1, 1'b1, acc);
    chk("pre_rst_bits", got_q.size(), 4);
    cycle(1'b0, 16'd0, 4'd0, 1'b0, 1'b0, acc);
    cycle(1'b0, 16'd0, 4'd0, 1'b1, 1'b1, acc);
    repeat (3) cycle(1'b0, 16'd0, 4'd0, 1'b1, 1'b1, acc);
    chk("abandon_bits", got_q.size(), 4);
    got_q.delete();
    pend_x.push_back(16'd5); pend_k.push_back(4'd1);
    run_queue(0, 0, 100, ncyc);
    chk("post_rst_pattern", got_pattern(), 32'b1111100);

    got_q.delete();
    pend_x.push_back(16'h8000); pend_k.push_back(4'd0);
    run_queue(0, 0, 70000, ncyc);
    chk("maxq_nbits", got_q.size(), 65536);
    chk("maxq_decode", decode(0), -32'sd32768);

    for (int n = 0; n < 150; n++) begin
      int k   = $urandom_range(0, 15);
      int lim = (k + 3 >= 15) ? 32767 : (1 << (k + 3)) - 1;
      int mag = $urandom_range(0, lim);
      int x   = ($urandom_range(0, 1) != 0) ? -mag : mag;
      pend_x.push_back(16'(x)); pend_k.push_back(4'(k));
    end
    run_queue(2, 1, 30000, ncyc);
    repeat (2) cycle(1'b0, 16'd0, 4'd0, 1'b1, 1'b1, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
